// File: rtl/axi4_lite_if_pkg.sv
// AXI4-Lite response codes shared by every block that talks on an axi4_lite_if.
package axi4_lite_if_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_t;

endpackage

// File: rtl/my_axi4_lite_slv_reg_file_pkg.sv
// Types and address helpers for the AXI4-Lite register file.
package my_axi4_lite_slv_reg_file_pkg;

   typedef enum logic {
      WR_IDLE = 1'b0,
      WR_RESP = 1'b1
   } wr_state_t;

   // Indices are carried at 64 bits so any address width compares cleanly.
   function automatic logic [63:0] word_idx(input logic [63:0] addr, input int unsigned addr_lsb);
      return addr >> addr_lsb;
   endfunction

   function automatic logic in_range(input logic [63:0] idx, input int unsigned num_regs);
      return idx < 64'(num_regs);
   endfunction

endpackage

// File: rtl/my_axi4_lite_slv_reg_file_if.sv
// AXI4-Lite bus bundle. Handshake rule on every channel: a transfer happens on a
// rising edge where VALID and READY are both 1; VALID, once raised, holds with stable payload until then.
interface axi4_lite_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport slv_port (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport mst_port (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/my_axi4_lite_slv_wr_ch.sv
// Write channel: captures AW and W independently, issues a one-cycle commit
// strobe once both are held, and runs the B response.
module my_axi4_lite_slv_wr_ch
   import axi4_lite_if_pkg::*;
   import my_axi4_lite_slv_reg_file_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            i_clk,
   input  logic            i_sync_rst_n,
   input  logic            i_awvalid,
   output logic            o_awready,
   input  logic [AW-1:0]   i_awaddr,
   input  logic            i_wvalid,
   output logic            o_wready,
   input  logic [DW-1:0]   i_wdata,
   input  logic [DW/8-1:0] i_wstrb,
   input  logic            i_bready,
   output logic [1:0]      o_bresp,
   input  logic [1:0]      i_commit_resp,
   output logic            o_commit,
   output logic [AW-1:0]   o_awaddr,
   output logic [DW-1:0]   o_wdata,
   output logic [DW/8-1:0] o_wstrb,
   output wr_state_t       o_wr_state
);

   wr_state_t       r_state;
   wr_state_t       w_state_nxt;
   logic            r_live;
   logic            r_aw_held;
   logic            r_w_held;
   logic [AW-1:0]   r_awaddr;
   logic [DW-1:0]   r_wdata;
   logic [DW/8-1:0] r_wstrb;
   logic [1:0]      r_bresp;

   always_ff @(posedge i_clk) begin
      if (!i_sync_rst_n) begin
         r_state <= WR_IDLE;
         r_live  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_live  <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         WR_IDLE: if (o_commit) w_state_nxt = WR_RESP;
         WR_RESP: if (i_bready) w_state_nxt = WR_IDLE;
         default: w_state_nxt = WR_IDLE;
      endcase
   end

   // Readies depend only on registers so no input-to-ready path exists.
   always_comb begin
      o_awready = r_live & ~r_aw_held & (r_state == WR_IDLE);
      o_wready  = r_live & ~r_w_held  & (r_state == WR_IDLE);
      o_commit  = r_aw_held & r_w_held & (r_state == WR_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (!i_sync_rst_n) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bresp   <= RESP_OKAY;
      end else if (o_commit) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_bresp   <= i_commit_resp;
      end else begin
         if (i_awvalid && o_awready) begin
            r_aw_held <= 1'b1;
            r_awaddr  <= i_awaddr;
         end
         if (i_wvalid && o_wready) begin
            r_w_held <= 1'b1;
            r_wdata  <= i_wdata;
            r_wstrb  <= i_wstrb;
         end
      end
   end

   assign o_bresp    = r_bresp;
   assign o_awaddr   = r_awaddr;
   assign o_wdata    = r_wdata;
   assign o_wstrb    = r_wstrb;
   assign o_wr_state = r_state;

endmodule

// File: rtl/my_axi4_lite_slv_reg_file.sv
// AXI4-Lite register file with read-only mask and live status import.
// MY_AXI4_LITE_SLV_REG_FILE_STRICT_RESP_EN: RO writes give SLVERR, out-of-range gives DECERR.
module my_axi4_lite_slv_reg_file
   import axi4_lite_if_pkg::*;
   import my_axi4_lite_slv_reg_file_pkg::*;
#(
   parameter int                  AXI4_LITE_ADDR_BIT_WIDTH = 32,
   parameter int                  AXI4_LITE_DATA_BIT_WIDTH = 32,
   parameter int                  NUM_REGS                 = 16,
   parameter logic [NUM_REGS-1:0] RO_MASK                  = '0
) (
   input  logic                                         i_clk,
   input  logic                                         i_sync_rst_n,
   axi4_lite_if.slv_port                                if_s_axi4_lite,
   output logic [NUM_REGS*AXI4_LITE_DATA_BIT_WIDTH-1:0] o_regs,
   output logic [NUM_REGS-1:0]                          o_wr_pulse,
   input  logic [NUM_REGS*AXI4_LITE_DATA_BIT_WIDTH-1:0] i_ro_regs
);

   localparam int AW       = AXI4_LITE_ADDR_BIT_WIDTH;
   localparam int DW       = AXI4_LITE_DATA_BIT_WIDTH;
   localparam int ADDR_LSB = $clog2(DW / 8);
   localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef MY_AXI4_LITE_SLV_REG_FILE_STRICT_RESP_EN
   localparam logic [1:0] OOR_RESP = RESP_DECERR;
   localparam logic [1:0] RO_RESP  = RESP_SLVERR;
`else
   localparam logic [1:0] OOR_RESP = RESP_SLVERR;
   localparam logic [1:0] RO_RESP  = RESP_OKAY;
`endif

   logic [DW-1:0]   r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_wr_pulse;

   logic            w_commit;
   logic [AW-1:0]   w_awaddr;
   logic [DW-1:0]   w_wdata;
   logic [DW/8-1:0] w_wstrb;
   logic [1:0]      w_commit_resp;
   wr_state_t       w_wr_state;

   my_axi4_lite_slv_wr_ch #(.AW(AW), .DW(DW)) u_wr_ch (
      .i_clk         (i_clk),
      .i_sync_rst_n  (i_sync_rst_n),
      .i_awvalid     (if_s_axi4_lite.awvalid),
      .o_awready     (if_s_axi4_lite.awready),
      .i_awaddr      (if_s_axi4_lite.awaddr),
      .i_wvalid      (if_s_axi4_lite.wvalid),
      .o_wready      (if_s_axi4_lite.wready),
      .i_wdata       (if_s_axi4_lite.wdata),
      .i_wstrb       (if_s_axi4_lite.wstrb),
      .i_bready      (if_s_axi4_lite.bready),
      .o_bresp       (if_s_axi4_lite.bresp),
      .i_commit_resp (w_commit_resp),
      .o_commit      (w_commit),
      .o_awaddr      (w_awaddr),
      .o_wdata       (w_wdata),
      .o_wstrb       (w_wstrb),
      .o_wr_state    (w_wr_state)
   );

   assign if_s_axi4_lite.bvalid = (w_wr_state == WR_RESP);

   // Write decode on the held address.
   logic [63:0]      w_wr_idx_full;
   logic [IDX_W-1:0] w_wr_idx;
   logic             w_wr_in_range;
   logic             w_wr_ro;
   logic             w_wr_ok;

   always_comb begin
      w_wr_idx_full = word_idx(64'(w_awaddr), ADDR_LSB);
      w_wr_idx      = w_wr_idx_full[IDX_W-1:0];
      w_wr_in_range = in_range(w_wr_idx_full, NUM_REGS);
      w_wr_ro       = w_wr_in_range & RO_MASK[w_wr_idx];
      w_wr_ok       = w_wr_in_range & ~w_wr_ro;
      w_commit_resp = RESP_OKAY;
      if (!w_wr_in_range)
         w_commit_resp = OOR_RESP;
      else if (w_wr_ro)
         w_commit_resp = RO_RESP;
   end

   always_ff @(posedge i_clk) begin
      if (!i_sync_rst_n) begin
         for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
         r_wr_pulse <= '0;
      end else begin
         r_wr_pulse <= '0;
         if (w_commit && w_wr_ok) begin
            r_wr_pulse[w_wr_idx] <= 1'b1;
            for (int b = 0; b < DW / 8; b++)
               if (w_wstrb[b]) r_regs[w_wr_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
         end
      end
   end

   assign o_wr_pulse = r_wr_pulse;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign o_regs[g*DW +: DW] = RO_MASK[g] ? '0 : r_regs[g];
   end

   // Read path: address captured on AR, data sampled one cycle later.
   logic             r_rd_live;
   logic             r_ar_pending;
   logic [AW-1:0]    r_araddr;
   logic             r_rvalid;
   logic [DW-1:0]    r_rdata;
   logic [1:0]       r_rresp;
   logic             w_arready;
   logic [63:0]      w_rd_idx_full;
   logic [IDX_W-1:0] w_rd_idx;
   logic             w_rd_in_range;
   logic [DW-1:0]    w_rd_val;

   always_comb begin
      w_arready     = r_rd_live & ~r_rvalid & ~r_ar_pending;
      w_rd_idx_full = word_idx(64'(r_araddr), ADDR_LSB);
      w_rd_idx      = w_rd_idx_full[IDX_W-1:0];
      w_rd_in_range = in_range(w_rd_idx_full, NUM_REGS);
      w_rd_val      = '0;
      if (w_rd_in_range)
         w_rd_val = RO_MASK[w_rd_idx] ? i_ro_regs[w_rd_idx*DW +: DW] : r_regs[w_rd_idx];
   end

   always_ff @(posedge i_clk) begin
      if (!i_sync_rst_n) begin
         r_rd_live    <= 1'b0;
         r_ar_pending <= 1'b0;
         r_araddr     <= '0;
         r_rvalid     <= 1'b0;
         r_rdata      <= '0;
         r_rresp      <= RESP_OKAY;
      end else begin
         r_rd_live <= 1'b1;
         if (if_s_axi4_lite.arvalid && w_arready) begin
            r_araddr     <= if_s_axi4_lite.araddr;
            r_ar_pending <= 1'b1;
         end
         if (r_ar_pending) begin
            r_ar_pending <= 1'b0;
            r_rvalid     <= 1'b1;
            r_rdata      <= w_rd_val;
            r_rresp      <= w_rd_in_range ? RESP_OKAY : OOR_RESP;
         end else if (r_rvalid && if_s_axi4_lite.rready) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   assign if_s_axi4_lite.arready = w_arready;
   assign if_s_axi4_lite.rvalid  = r_rvalid;
   assign if_s_axi4_lite.rdata   = r_rdata;
   assign if_s_axi4_lite.rresp   = r_rresp;

endmodule

// File: tb/tb_my_axi4_lite_slv_reg_file.sv
// Self-checking bench for my_axi4_lite_slv_reg_file (16 regs, register 1 read-only).
module tb_my_axi4_lite_slv_reg_file;
   import axi4_lite_if_pkg::*;

   localparam int NREG = 16;
   localparam int DW   = 32;
   localparam logic [NREG-1:0] RO_MASK = 16'h0002;
`ifdef MY_AXI4_LITE_SLV_REG_FILE_STRICT_RESP_EN
   localparam logic [1:0] EXP_OOR = 2'b11;
   localparam logic [1:0] EXP_RO  = 2'b10;
`else
   localparam logic [1:0] EXP_OOR = 2'b10;
   localparam logic [1:0] EXP_RO  = 2'b00;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   axi4_lite_if #(.ADDR_W(32), .DATA_W(DW)) axi ();
   logic [NREG*DW-1:0] o_regs;
   logic [NREG*DW-1:0] ro_regs;
   logic [NREG-1:0]    wr_pulse;

   my_axi4_lite_slv_reg_file #(
      .AXI4_LITE_ADDR_BIT_WIDTH(32),
      .AXI4_LITE_DATA_BIT_WIDTH(DW),
      .NUM_REGS(NREG),
      .RO_MASK(RO_MASK)
   ) dut (
      .i_clk          (clk),
      .i_sync_rst_n   (rst_n),
      .if_s_axi4_lite (axi),
      .o_regs         (o_regs),
      .o_wr_pulse     (wr_pulse),
      .i_ro_regs      (ro_regs)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [DW-1:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_aw(input logic [31:0] a);
      logic done;
      done = 1'b0;
      axi.awaddr = a; axi.awvalid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk); done = axi.awready;
         @(posedge clk); #1;
      end
      axi.awvalid = 1'b0;
      if (!done) check("aw_timeout", 0, 1);
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      logic done;
      done = 1'b0;
      axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk); done = axi.wready;
         @(posedge clk); #1;
      end
      axi.wvalid = 1'b0;
      if (!done) check("w_timeout", 0, 1);
   endtask

   task automatic send_ar(input logic [31:0] a);
      logic done;
      done = 1'b0;
      axi.araddr = a; axi.arvalid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk); done = axi.arready;
         @(posedge clk); #1;
      end
      axi.arvalid = 1'b0;
      if (!done) check("ar_timeout", 0, 1);
   endtask

   task automatic wait_b(output logic [1:0] resp, output logic [NREG-1:0] pulses);
      pulses = '0;
      for (int i = 0; i < 20 && !axi.bvalid; i++) begin
         pulses |= wr_pulse;
         @(posedge clk); #1;
      end
      pulses |= wr_pulse;
      if (!axi.bvalid) check("b_timeout", 0, 1);
      resp = axi.bresp;
      axi.bready = 1'b1;
      @(posedge clk); #1;
      axi.bready = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic w_first, output logic [1:0] resp, output logic [NREG-1:0] pulses);
      if (w_first) begin
         send_w(d, s); send_aw(a);
      end else begin
         send_aw(a); send_w(d, s);
      end
      wait_b(resp, pulses);
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      send_ar(a);
      for (int i = 0; i < 20 && !axi.rvalid; i++) begin
         @(posedge clk); #1;
      end
      if (!axi.rvalid) check("r_timeout", 0, 1);
      d = axi.rdata; resp = axi.rresp;
      axi.rready = 1'b1;
      @(posedge clk); #1;
      axi.rready = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        is_wr;
      logic        w_first;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
      logic [15:0] exp_pulse;
   } vec_t;

   localparam int NVEC = 15;
   vec_t vecs[NVEC];

   initial begin
      logic [1:0]      resp;
      logic [NREG-1:0] pulses;
      logic [31:0]     rd;
      logic            hold_ok;
      logic            aw_hs, w_hs;

      vecs[0]  = '{1'b0, 1'b0, 32'h08, 32'h0,        4'h0, 2'b00,   32'hDEADBEEF, 16'h0000};
      vecs[1]  = '{1'b1, 1'b0, 32'h0C, 32'hDEADBEEF, 4'hF, 2'b00,   32'h0,        16'h0008};
      vecs[2]  = '{1'b1, 1'b1, 32'h0C, 32'h11223344, 4'h5, 2'b00,   32'h0,        16'h0008};
      vecs[3]  = '{1'b0, 1'b0, 32'h0C, 32'h0,        4'h0, 2'b00,   32'hDE22BE44, 16'h0000};
      vecs[4]  = '{1'b1, 1'b0, 32'h40, 32'h12345678, 4'hF, EXP_OOR, 32'h0,        16'h0000};
      vecs[5]  = '{1'b0, 1'b0, 32'h40, 32'h0,        4'h0, EXP_OOR, 32'h0,        16'h0000};
      vecs[6]  = '{1'b1, 1'b1, 32'h04, 32'h12345678, 4'hF, EXP_RO,  32'h0,        16'h0000};
      vecs[7]  = '{1'b0, 1'b0, 32'h04, 32'h0,        4'h0, 2'b00,   32'hCAFE0001, 16'h0000};
      vecs[8]  = '{1'b1, 1'b0, 32'h3F, 32'hA5A5A5A5, 4'hF, 2'b00,   32'h0,        16'h8000};
      vecs[9]  = '{1'b0, 1'b0, 32'h3E, 32'h0,        4'h0, 2'b00,   32'hA5A5A5A5, 16'h0000};
      vecs[10] = '{1'b1, 1'b0, 32'h00, 32'h0BADF00D, 4'hF, 2'b00,   32'h0,        16'h0001};
      vecs[11] = '{1'b1, 1'b1, 32'h00, 32'hFFFFFFFF, 4'h0, 2'b00,   32'h0,        16'h0001};
      vecs[12] = '{1'b0, 1'b0, 32'h01, 32'h0,        4'h0, 2'b00,   32'h0BADF00D, 16'h0000};
      vecs[13] = '{1'b1, 1'b0, 32'hFFFFFFF0, 32'h1, 4'hF, EXP_OOR, 32'h0,        16'h0000};
      vecs[14] = '{1'b0, 1'b0, 32'h10, 32'h0,        4'h0, 2'b00,   32'h0,        16'h0000};

      for (int k = 0; k < NREG; k++) ro_regs[k*DW +: DW] = 32'h5A000000 | 32'(k);
      ro_regs[1*DW +: DW] = 32'hCAFE0001;
      axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
      axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

      // reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {axi.awready, axi.wready, axi.arready}, 3'b000);
      check("rst_valid", {axi.bvalid, axi.rvalid}, 2'b00);
      check("rst_regs", (o_regs == '0), 1);
      check("rst_pulse", wr_pulse, 0);
      check("rst_resp", {axi.bresp, axi.rresp, axi.rdata}, 0);
      rst_n = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      check("live_ready", {axi.awready, axi.wready, axi.arready}, 3'b111);

      // AW in cycle 0, W in cycle 3, commit latency
      send_aw(32'h08);
      check("aw_held_ready", axi.awready, 0);
      repeat (2) begin @(posedge clk); #1; end
      send_w(32'hDEADBEEF, 4'hF);
      check("no_early_b", {axi.bvalid, wr_pulse}, 0);
      @(posedge clk); #1;
      check("b_latency", axi.bvalid, 1);
      check("b_okay", axi.bresp, 2'b00);
      check("pulse_reg2", wr_pulse, 16'h0004);
      check("oregs_reg2", o_regs[2*DW +: DW], 32'hDEADBEEF);
      @(posedge clk); #1;
      check("pulse_once", wr_pulse, 0);
      check("b_hold", axi.bvalid, 1);
      axi.bready = 1'b1;
      @(posedge clk); #1;
      axi.bready = 1'b0;
      check("b_clear", axi.bvalid, 0);

      // table-driven vectors
      for (int i = 0; i < NVEC; i++) begin
         if (vecs[i].is_wr) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].w_first, resp, pulses);
            check($sformatf("v%0d_bresp", i), resp, vecs[i].exp_resp);
            check($sformatf("v%0d_pulse", i), pulses, vecs[i].exp_pulse);
         end else begin
            exp_q.push_back(vecs[i].exp_rdata);
            do_read(vecs[i].addr, rd, resp);
            check($sformatf("v%0d_rresp", i), resp, vecs[i].exp_resp);
            check($sformatf("v%0d_rdata", i), rd, exp_q.pop_front());
         end
      end
      check("oregs_ro_zero", o_regs[1*DW +: DW], 0);
      check("oregs_reg15", o_regs[15*DW +: DW], 32'hA5A5A5A5);
      check("oregs_reg3", o_regs[3*DW +: DW], 32'hDE22BE44);

      // BREADY held low for 10 cycles with a second write waiting
      send_aw(32'h10);
      send_w(32'h44444444, 4'hF);
      for (int i = 0; i < 20 && !axi.bvalid; i++) begin @(posedge clk); #1; end
      check("bhold_bvalid", axi.bvalid, 1);
      axi.awaddr = 32'h14; axi.awvalid = 1'b1;
      axi.wdata = 32'h55555555; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
      hold_ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (!(axi.bvalid && axi.bresp == 2'b00 && !axi.awready && !axi.wready)) hold_ok = 1'b0;
         @(posedge clk); #1;
      end
      check("bhold_stable", hold_ok, 1);
      check("bhold_reg4", o_regs[4*DW +: DW], 32'h44444444);
      check("bhold_reg5_untouched", o_regs[5*DW +: DW], 0);
      axi.bready = 1'b1;
      @(negedge clk);
      check("bhold_no_accept_at_b", {axi.awready, axi.wready}, 2'b00);
      @(posedge clk); #1;
      axi.bready = 1'b0;
      for (int i = 0; i < 20 && (axi.awvalid || axi.wvalid); i++) begin
         @(negedge clk);
         aw_hs = axi.awvalid & axi.awready;
         w_hs  = axi.wvalid & axi.wready;
         @(posedge clk); #1;
         if (aw_hs) axi.awvalid = 1'b0;
         if (w_hs)  axi.wvalid = 1'b0;
      end
      check("second_accepted", {axi.awvalid, axi.wvalid}, 2'b00);
      wait_b(resp, pulses);
      check("second_bresp", resp, 2'b00);
      check("second_pulse", pulses, 16'h0020);
      check("second_reg5", o_regs[5*DW +: DW], 32'h55555555);

      // read and commit to the same register in one cycle
      do_write(32'h18, 32'h66666666, 4'hF, 1'b0, resp, pulses);
      axi.awaddr = 32'h18; axi.awvalid = 1'b1;
      axi.wdata = 32'h77777777; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
      axi.araddr = 32'h18; axi.arvalid = 1'b1;
      @(negedge clk);
      check("sim_all_ready", {axi.awready, axi.wready, axi.arready}, 3'b111);
      @(posedge clk); #1;
      axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
      @(posedge clk); #1;
      check("sim_rvalid_bvalid", {axi.rvalid, axi.bvalid}, 2'b11);
      check("sim_pre_commit", axi.rdata, 32'h66666666);
      check("sim_pulse", wr_pulse, 16'h0040);
      axi.rready = 1'b1; axi.bready = 1'b1;
      @(posedge clk); #1;
      axi.rready = 1'b0; axi.bready = 1'b0;
      do_read(32'h18, rd, resp);
      check("sim_post_commit", rd, 32'h77777777);

      // reset while AW is held and W never sent
      send_aw(32'h18);
      rst_n = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      hold_ok = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         if (axi.bvalid || wr_pulse != '0) hold_ok = 1'b0;
      end
      check("rst_abort_no_commit", hold_ok, 1);
      check("rst_abort_regs", (o_regs == '0), 1);
      send_w(32'h99999999, 4'hF);
      hold_ok = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         if (axi.bvalid) hold_ok = 1'b0;
      end
      check("w_only_no_commit", hold_ok, 1);
      send_aw(32'h1C);
      wait_b(resp, pulses);
      check("after_rst_bresp", resp, 2'b00);
      check("after_rst_pulse", pulses, 16'h0080);
      check("after_rst_reg7", o_regs[7*DW +: DW], 32'h99999999);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      n_errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
